// File: rtl/alu_arbiter.sv
// ---------------------------------------------------------------------------
// alu_arbiter
//   Round-robin arbiter/sequencer sharing one combinational 2-bit ALU
//   (00 SUM, 01 SUB, 10 AND, 11 OR; flags {Z,C,V,S}) between NUM_REQ
//   requesters. One operation is in flight at a time: IDLE -> EXEC -> RESP.
//
// Parameters
//   NUM_REQ     number of requesters (2..8), index 0 served first after reset
//
// Ports
//   clk         system clock, all state on rising edge
//   rst         synchronous active-high reset
//   req_valid   per-requester request
//   req_ready   one-hot combinational grant, only in IDLE
//   req_select  op codes, requester i at [2i+1:2i]
//   req_a/req_b operands, same packing
//   alu_select/alu_a/alu_b  registered operands driven to the ALU
//   alu_result/alu_flags    ALU outputs, captured at the end of EXEC
//   rsp_valid   one-hot, one-cycle response pulse to the owner
//   rsp_result/rsp_flags    captured result/flags, held after RESP
//   busy        high in EXEC and RESP
//   perf_ops/perf_stall     performance counters
//
// Configuration
//   ALU_ARB_PERF_EN  when defined, builds saturating perf_ops/perf_stall
//                    counters; otherwise both outputs are tied to zero.
// ---------------------------------------------------------------------------
module alu_arbiter #(
    parameter int NUM_REQ = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [2*NUM_REQ-1:0]   req_select,
    input  logic [2*NUM_REQ-1:0]   req_a,
    input  logic [2*NUM_REQ-1:0]   req_b,
    output logic [1:0]             alu_select,
    output logic [1:0]             alu_a,
    output logic [1:0]             alu_b,
    input  logic [1:0]             alu_result,
    input  logic [3:0]             alu_flags,
    output logic [NUM_REQ-1:0]     rsp_valid,
    output logic [1:0]             rsp_result,
    output logic [3:0]             rsp_flags,
    output logic                   busy,
    output logic [15:0]            perf_ops,
    output logic [15:0]            perf_stall
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [IW-1:0]        r_last_grant;
    logic [IW-1:0]        r_owner;
    logic [IW-1:0]        w_win_idx;
    logic                 w_win_found;
    logic [NUM_REQ-1:0]   w_win_onehot;
    logic [NUM_REQ-1:0]   w_owner_onehot;
    logic                 w_xfer;
    logic [1:0]           r_alu_select;
    logic [1:0]           r_alu_a;
    logic [1:0]           r_alu_b;
    logic [NUM_REQ-1:0]   r_rsp_valid;
    logic [1:0]           r_rsp_result;
    logic [3:0]           r_rsp_flags;

    // Round-robin search: first valid requester starting at last_grant+1, with wrap.
    always_comb begin
        int w_idx_i;
        w_win_found = 1'b0;
        w_win_idx   = '0;
        w_idx_i     = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_idx_i = (int'(r_last_grant) + k) % NUM_REQ;
            if (!w_win_found && req_valid[IW'(w_idx_i)]) begin
                w_win_found = 1'b1;
                w_win_idx   = IW'(w_idx_i);
            end else begin
                w_win_found = w_win_found;
            end
        end
    end

    // One-hot decode of the winner and of the current owner.
    always_comb begin
        w_win_onehot              = '0;
        w_win_onehot[w_win_idx]   = w_win_found;
        w_owner_onehot            = '0;
        w_owner_onehot[r_owner]   = 1'b1;
    end

    assign w_xfer = |(req_valid & req_ready);

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_xfer) begin
                    w_state_nxt = ST_EXEC;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_EXEC: w_state_nxt = ST_RESP;
            ST_RESP: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // FSM outputs: grants only while idle, busy while an op is in flight.
    always_comb begin
        req_ready = '0;
        busy      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                req_ready = w_win_onehot;
                busy      = 1'b0;
            end
            ST_EXEC, ST_RESP: begin
                req_ready = '0;
                busy      = 1'b1;
            end
            default: begin
                req_ready = '0;
                busy      = 1'b0;
            end
        endcase
    end

    // State register, operand latch on transfer, response capture at end of EXEC.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_last_grant <= IW'(NUM_REQ - 1);
            r_owner      <= '0;
            r_alu_select <= 2'b00;
            r_alu_a      <= 2'b00;
            r_alu_b      <= 2'b00;
            r_rsp_valid  <= '0;
            r_rsp_result <= 2'b00;
            r_rsp_flags  <= 4'b0000;
        end else begin
            r_state <= w_state_nxt;
            if (w_xfer) begin
                r_alu_select <= req_select[{w_win_idx, 1'b0} +: 2];
                r_alu_a      <= req_a[{w_win_idx, 1'b0} +: 2];
                r_alu_b      <= req_b[{w_win_idx, 1'b0} +: 2];
                r_owner      <= w_win_idx;
                r_last_grant <= w_win_idx;
            end
            if (r_state == ST_EXEC) begin
                r_rsp_result <= alu_result;
                r_rsp_flags  <= alu_flags;
                r_rsp_valid  <= w_owner_onehot;
            end else begin
                r_rsp_valid  <= '0;
            end
        end
    end

    assign alu_select = r_alu_select;
    assign alu_a      = r_alu_a;
    assign alu_b      = r_alu_b;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_result = r_rsp_result;
    assign rsp_flags  = r_rsp_flags;

`ifdef ALU_ARB_PERF_EN
    logic [15:0] r_perf_ops;
    logic [15:0] r_perf_stall;

    // Saturating counters: completed ops and cycles with a pending but untransferred request.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_ops   <= 16'd0;
            r_perf_stall <= 16'd0;
        end else begin
            if ((r_state == ST_RESP) && (r_perf_ops != 16'hFFFF)) begin
                r_perf_ops <= r_perf_ops + 16'd1;
            end
            if ((|req_valid) && !w_xfer && (r_perf_stall != 16'hFFFF)) begin
                r_perf_stall <= r_perf_stall + 16'd1;
            end
        end
    end

    assign perf_ops   = r_perf_ops;
    assign perf_stall = r_perf_stall;
`else
    assign perf_ops   = 16'd0;
    assign perf_stall = 16'd0;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// ---------------------------------------------------------------------------
// tb_alu_arbiter
//   Directed bench for alu_arbiter with NUM_REQ=2. A behavioural ALU closes
//   the loop on alu_* ports. Stimulus sets per-requester operands together
//   with hand-computed expected result/flags; a negedge monitor pushes an
//   expectation on every observed transfer and pops/compares on every
//   response pulse, including the T+2 latency.
// ---------------------------------------------------------------------------
module tb_alu_arbiter;

    localparam int NREQ = 2;

    logic              clk;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [2*NREQ-1:0] req_select;
    logic [2*NREQ-1:0] req_a;
    logic [2*NREQ-1:0] req_b;
    logic [1:0]        alu_select;
    logic [1:0]        alu_a;
    logic [1:0]        alu_b;
    logic [1:0]        alu_result;
    logic [3:0]        alu_flags;
    logic [NREQ-1:0]   rsp_valid;
    logic [1:0]        rsp_result;
    logic [3:0]        rsp_flags;
    logic              busy;
    logic [15:0]       perf_ops;
    logic [15:0]       perf_stall;

    alu_arbiter #(.NUM_REQ(NREQ)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_select (req_select),
        .req_a      (req_a),
        .req_b      (req_b),
        .alu_select (alu_select),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_result (alu_result),
        .alu_flags  (alu_flags),
        .rsp_valid  (rsp_valid),
        .rsp_result (rsp_result),
        .rsp_flags  (rsp_flags),
        .busy       (busy),
        .perf_ops   (perf_ops),
        .perf_stall (perf_stall)
    );

    // Behavioural stand-in for the shared ALU.
    always_comb begin
        logic [2:0] t;
        logic c;
        logic v;
        t = 3'd0;
        c = 1'b0;
        v = 1'b0;
        case (alu_select)
            2'b00: begin
                t = {1'b0, alu_a} + {1'b0, alu_b};
                c = t[2];
                v = (alu_a[1] == alu_b[1]) && (t[1] != alu_a[1]);
            end
            2'b01: begin
                t = {1'b0, alu_a} + {1'b0, ~alu_b} + 3'd1;
                c = t[2];
                v = (alu_a[1] != alu_b[1]) && (t[1] != alu_a[1]);
            end
            2'b10: t = {1'b0, alu_a & alu_b};
            default: t = {1'b0, alu_a | alu_b};
        endcase
        alu_result = t[1:0];
        alu_flags  = {(t[1:0] == 2'b00), c, v, t[1]};
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         idx;
        logic [1:0] res;
        logic [3:0] flg;
        int         due;
    } sb_t;

    sb_t        sb_q[$];
    int         grant_log[$];
    int         grant_cyc[$];
    int         n_grants = 0;
    int         n_checks = 0;
    int         n_errors = 0;
    logic [1:0] exp_res[NREQ];
    logic [3:0] exp_flg[NREQ];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor/scoreboard: push on transfer, pop and compare on response.
    always @(negedge clk) begin
        sb_t e;
        logic [NREQ-1:0] ev;
        if (rst) begin
            sb_q.delete();
        end else begin
            if (busy) chk("ready_outside_idle", 32'(req_ready), 32'd0);
            for (int g = 0; g < NREQ; g++) begin
                if (req_valid[g] & req_ready[g]) begin
                    sb_q.push_back('{idx: g, res: exp_res[g], flg: exp_flg[g], due: cyc + 2});
                    grant_log.push_back(g);
                    grant_cyc.push_back(cyc);
                    n_grants++;
                end
            end
            if (rsp_valid != '0) begin
                if (sb_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_rsp: rsp_valid=%0b expected none", rsp_valid);
                end else begin
                    e = sb_q.pop_front();
                    ev = '0;
                    ev[e.idx] = 1'b1;
                    chk("rsp_valid", 32'(rsp_valid), 32'(ev));
                    chk("rsp_result", 32'(rsp_result), 32'(e.res));
                    chk("rsp_flags", 32'(rsp_flags), 32'(e.flg));
                    chk("rsp_latency", 32'(cyc), 32'(e.due));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input logic [1:0] op,
                           input logic [1:0] a, input logic [1:0] b,
                           input logic [1:0] er, input logic [3:0] ef);
        req_valid[i]        = v;
        req_select[2*i +: 2] = op;
        req_a[2*i +: 2]      = a;
        req_b[2*i +: 2]      = b;
        exp_res[i]          = er;
        exp_flg[i]          = ef;
    endtask

    // Wait until n_grants reaches target, then align to just after the transfer edge.
    task automatic wait_grants(input int target, input int budget);
        int c;
        c = 0;
        while (n_grants < target && c < budget) begin
            tick();
            c++;
        end
        if (n_grants < target) begin
            chk("grant_timeout", 32'(n_grants), 32'(target));
        end else begin
            while (cyc <= grant_cyc[grant_cyc.size()-1]) tick();
        end
    endtask

    task automatic do_op(input int i, input logic [1:0] op, input logic [1:0] a,
                         input logic [1:0] b, input logic [1:0] er, input logic [3:0] ef);
        set_req(i, 1'b1, op, a, b, er, ef);
        wait_grants(n_grants + 1, 10);
        req_valid[i] = 1'b0;
        repeat (3) tick();
    endtask

    initial begin
        int base;
        int base_n;
        rst        = 1'b1;
        req_valid  = '0;
        req_select = '0;
        req_a      = '0;
        req_b      = '0;
        for (int i = 0; i < NREQ; i++) begin
            exp_res[i] = 2'b00;
            exp_flg[i] = 4'b0000;
        end
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_result", 32'(rsp_result), 32'd0);
        chk("rst_rsp_flags", 32'(rsp_flags), 32'd0);
        chk("rst_alu", 32'({alu_select, alu_a, alu_b}), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_perf", 32'({perf_ops, perf_stall}), 32'd0);
        tick();

        // req0 SUM 01+01 -> 10, {Z,C,V,S}=0011, with busy window and hold checks
        set_req(0, 1'b1, 2'b00, 2'b01, 2'b01, 2'b10, 4'b0011);
        wait_grants(n_grants + 1, 10);
        req_valid[0] = 1'b0;
        @(negedge clk);
        chk("busy_t1", 32'(busy), 32'd1);
        chk("alu_ops_t1", 32'({alu_select, alu_a, alu_b}), 32'b00_01_01);
        @(negedge clk);
        chk("busy_t2", 32'(busy), 32'd1);
        @(negedge clk);
        chk("busy_t3", 32'(busy), 32'd0);
        @(negedge clk);
        chk("hold_result", 32'(rsp_result), 32'b10);
        chk("hold_flags", 32'(rsp_flags), 32'b0011);
        chk("hold_rsp_valid", 32'(rsp_valid), 32'd0);
        tick();

        // req1 alone: SUB 01-10 -> 11/0011, SUM 11+01 -> 00/1100
        do_op(1, 2'b01, 2'b01, 2'b10, 2'b11, 4'b0011);
        do_op(1, 2'b00, 2'b11, 2'b01, 2'b00, 4'b1100);

        // Both continuously valid after reset: grants 0,1,0,1 three cycles apart
        rst = 1'b1;
        tick();
        rst = 1'b0;
        base = grant_log.size();
        set_req(0, 1'b1, 2'b10, 2'b11, 2'b10, 2'b10, 4'b0001);
        set_req(1, 1'b1, 2'b11, 2'b00, 2'b00, 2'b00, 4'b1000);
        wait_grants(n_grants + 4, 30);
        req_valid = '0;
        repeat (3) tick();
        for (int k = 0; k < 4; k++) begin
            if (base + k < grant_log.size()) begin
                chk($sformatf("rr_order_%0d", k), 32'(grant_log[base + k]), 32'(k % 2));
                if (k > 0) chk($sformatf("rr_spacing_%0d", k),
                               32'(grant_cyc[base + k] - grant_cyc[base + k - 1]), 32'd3);
            end else begin
                chk($sformatf("rr_missing_%0d", k), 32'(grant_log.size()), 32'(base + k + 1));
            end
        end
        @(negedge clk);
`ifdef ALU_ARB_PERF_EN
        chk("perf_ops", 32'(perf_ops), 32'd4);
        chk("perf_stall", 32'(perf_stall), 32'd6);
`else
        chk("perf_ops", 32'(perf_ops), 32'd0);
        chk("perf_stall", 32'(perf_stall), 32'd0);
`endif
        tick();

        // Reset during EXEC: op discarded, req0 wins first again
        do_op(1, 2'b11, 2'b01, 2'b10, 2'b11, 4'b0001);
        set_req(0, 1'b1, 2'b00, 2'b01, 2'b01, 2'b10, 4'b0011);
        wait_grants(n_grants + 1, 10);
        rst = 1'b1;
        set_req(1, 1'b1, 2'b11, 2'b00, 2'b00, 2'b00, 4'b1000);
        tick();
        rst = 1'b0;
        base   = grant_log.size();
        base_n = n_grants;
        @(negedge clk);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_rsp", 32'({rsp_valid, rsp_result, rsp_flags}), 32'd0);
        chk("mid_rst_alu", 32'({alu_select, alu_a, alu_b}), 32'd0);
        chk("mid_rst_perf", 32'({perf_ops, perf_stall}), 32'd0);
        chk("mid_rst_ready", 32'(req_ready), 32'b01);
        wait_grants(base_n + 1, 10);
        req_valid[0] = 1'b0;
        if (grant_log.size() > base) chk("mid_rst_first", 32'(grant_log[base]), 32'd0);
        wait_grants(base_n + 2, 10);
        req_valid[1] = 1'b0;
        if (grant_log.size() > base + 1) chk("mid_rst_second", 32'(grant_log[base + 1]), 32'd1);
        repeat (3) tick();

        // req1 raised and dropped while req0 is in flight: no grant, no response
        set_req(0, 1'b1, 2'b00, 2'b11, 2'b01, 2'b00, 4'b1100);
        wait_grants(n_grants + 1, 10);
        req_valid[0] = 1'b0;
        set_req(1, 1'b1, 2'b11, 2'b01, 2'b01, 2'b01, 4'b0000);
        tick();
        req_valid[1] = 1'b0;
        base_n = n_grants;
        repeat (5) tick();
        @(negedge clk);
        chk("drop_no_grant", 32'(n_grants), 32'(base_n));
        chk("drop_ready", 32'(req_ready), 32'd0);
        chk("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
